// File: rtl/sb_axi_burst_ctrl_pkg.sv
// Shared AXI constants, FSM state type and helpers for sb_axi_burst_ctrl.
// Contents:
//   AXI_BURST_INCR, AXI_RESP_*, AXI_CACHE_DEFAULT  fixed AXI field encodings
//   state_e                                        burst sequencer FSM states
//   axi_size_of(strb_width)                        AxSIZE for a given strobe width
package sb_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR,
    StRsp
  } state_e;

  // log2 of the strobe width; strobe width is a power of two by construction.
  function automatic logic [2:0] axi_size_of(input int unsigned strb_width);
    logic [2:0] size;
    size = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == strb_width) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/sb_axi_burst_ctrl_if.sv
// AXI4 master-port bundle used by sb_axi_burst_ctrl.
// Modports:
//   master  burst controller side: drives AW/W/AR channels, bready, rready
//   slave   memory / bench side: drives ready on AW/W/AR, B and R channels
interface sb_axi_burst_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 8
) ();

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Write address
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  // Write data
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // Write response
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // Read address
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  // Read data
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/sb_axi_burst_ctrl.sv
// Single-outstanding AXI4 burst sequencer. Takes one read or write command at a time,
// issues AW or AR, passes W beats from the requester and R beats back to it, and
// returns one merged response per command.
// Ports:
//   clk, nreset                         clock, asynchronous active-low reset
//   cmd_*                               command handshake (write, addr, len)
//   wd_*                                write beat stream from the requester
//   rd_*                                read beat stream to the requester
//   rsp_*                               completion (type, merged response)
//   m_axi                               AXI4 master port (interface, master modport)
module sb_axi_burst_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned AXI_ID     = 0
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic [STRB_WIDTH-1:0] wd_strb,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [1:0]            rsp_resp,
  sb_axi_burst_ctrl_if.master   m_axi
);
  import sb_axi_pkg::*;

  localparam logic [2:0]            AxSize   = axi_size_of(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AddrMask = ~ADDR_WIDTH'((32'd1 << AxSize) - 32'd1);

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic                  write_q;
  logic [7:0]            count_q;
  logic [1:0]            resp_q;
  logic                  awvalid_q;
  logic                  arvalid_q;
  logic                  bready_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;

  logic       at_last;
  logic       w_hs;
  logic       r_hs;
  logic [1:0] r_resp;

  assign at_last = (count_q == len_q);
  assign w_hs    = (state_q == StW) && wd_valid && m_axi.wready;
  assign r_hs    = (state_q == StR) && m_axi.rvalid && rd_ready;

  // First non-OKAY response is kept; an rlast that disagrees with the beat count
  // overrides everything with SLVERR.
  always_comb begin
    r_resp = resp_q;
    if (resp_q == AXI_RESP_OKAY) r_resp = m_axi.rresp;
    if (m_axi.rlast != at_last) r_resp = AXI_RESP_SLVERR;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      write_q     <= 1'b0;
      count_q     <= '0;
      resp_q      <= AXI_RESP_OKAY;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr & AddrMask;
            len_q       <= cmd_len;
            write_q     <= cmd_write;
            count_q     <= '0;
            resp_q      <= AXI_RESP_OKAY;
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              state_q   <= StAw;
              awvalid_q <= 1'b1;
            end else begin
              state_q   <= StAr;
              arvalid_q <= 1'b1;
            end
          end
        end
        StAw: begin
          if (m_axi.awready) begin
            awvalid_q <= 1'b0;
            state_q   <= StW;
          end
        end
        StW: begin
          if (w_hs) begin
            if (at_last) begin
              state_q  <= StB;
              bready_q <= 1'b1;
            end else begin
              count_q <= count_q + 8'd1;
            end
          end
        end
        StB: begin
          if (m_axi.bvalid) begin
            resp_q      <= m_axi.bresp;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StRsp;
          end
        end
        StAr: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StR;
          end
        end
        StR: begin
          if (r_hs) begin
            resp_q <= r_resp;
            // Count saturates at len so an overlong burst never wraps rd_last.
            if (!at_last) count_q <= count_q + 8'd1;
            if (m_axi.rlast) begin
              rsp_valid_q <= 1'b1;
              state_q     <= StRsp;
            end
          end
        end
        StRsp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Requester side
  assign cmd_ready = cmd_ready_q;
  assign wd_ready  = (state_q == StW) && m_axi.wready;
  assign rd_valid  = (state_q == StR) && m_axi.rvalid;
  assign rd_data   = m_axi.rdata;
  assign rd_last   = at_last;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = write_q;
  assign rsp_resp  = resp_q;

  // Write address
  assign m_axi.awid    = ID_WIDTH'(AXI_ID);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AxSize;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_DEFAULT;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  // Write data
  assign m_axi.wdata   = wd_data;
  assign m_axi.wstrb   = wd_strb;
  assign m_axi.wlast   = at_last;
  assign m_axi.wvalid  = (state_q == StW) && wd_valid;
  assign m_axi.bready  = bready_q;
  // Read address
  assign m_axi.arid    = ID_WIDTH'(AXI_ID);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = AxSize;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = AXI_CACHE_DEFAULT;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = (state_q == StR) && rd_ready;

endmodule

// File: tb/tb_sb_axi_burst_ctrl.sv
// Directed self-checking bench for sb_axi_burst_ctrl. The bench plays both the
// requester and the AXI slave; every expected value is hand-derived.
module tb_sb_axi_burst_ctrl;
  import sb_axi_pkg::*;

  localparam int Budget = 3000;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [1:0]  rsp_resp;

  int checks = 0;
  int failures = 0;

  sb_axi_burst_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(8)) axi ();

  sb_axi_burst_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(16),
    .STRB_WIDTH(4),
    .ID_WIDTH  (8),
    .AXI_ID    (0)
  ) dut (
    .clk      (clk),
    .nreset   (nreset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .wd_strb  (wd_strb),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_resp (rsp_resp),
    .m_axi    (axi)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [15:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_len   = len;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_busy", cmd_ready, 1'b0);
  endtask

  task automatic addr_phase(input logic wr, input logic [15:0] exp_addr, input logic [7:0] len,
                            input bit stall);
    bit   done;
    int   cyc;
    logic rdy;
    done = 1'b0;
    cyc  = 0;
    if (wr) begin
      chk("awsize", axi.awsize, 3'd2);
      chk("awburst", axi.awburst, 2'b01);
      chk("awcache", axi.awcache, 4'b0011);
      chk("awprot_lock_id", {axi.awprot, axi.awlock, axi.awid}, 12'h000);
    end else begin
      chk("arsize", axi.arsize, 3'd2);
      chk("arburst", axi.arburst, 2'b01);
      chk("arcache", axi.arcache, 4'b0011);
      chk("arprot_lock_id", {axi.arprot, axi.arlock, axi.arid}, 12'h000);
    end
    while (!done && cyc < Budget) begin
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wr) axi.awready = rdy;
      else    axi.arready = rdy;
      #1;
      if (wr) begin
        chk("awvalid", axi.awvalid, 1'b1);
        chk("awaddr", axi.awaddr, exp_addr);
        chk("awlen", axi.awlen, len);
        chk("arvalid_in_aw", axi.arvalid, 1'b0);
      end else begin
        chk("arvalid", axi.arvalid, 1'b1);
        chk("araddr", axi.araddr, exp_addr);
        chk("arlen", axi.arlen, len);
        chk("awvalid_in_ar", axi.awvalid, 1'b0);
      end
      chk("cmd_ready_addr", cmd_ready, 1'b0);
      done = rdy;
      step();
      cyc++;
    end
    axi.awready = 1'b0;
    axi.arready = 1'b0;
    chk("addr_done", done, 1'b1);
  endtask

  task automatic wdata_phase(input int len, input logic [31:0] base, input bit stall,
                             input int stop_after, input int exp_beats);
    int beat;
    int cyc;
    bit hs;
    beat = 0;
    cyc  = 0;
    wd_valid = 1'b0;
    while (beat <= len && beat < stop_after && cyc < Budget) begin
      // Once offered, a beat stays valid until it is taken.
      if (!wd_valid) wd_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wd_data    = base + 32'(beat);
      wd_strb    = 4'hF;
      axi.wready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("wvalid", axi.wvalid, wd_valid);
      chk("wd_ready", wd_ready, axi.wready);
      chk("wdata", axi.wdata, base + 32'(beat));
      chk("wstrb", axi.wstrb, 4'hF);
      chk("wlast", axi.wlast, beat == len);
      chk("cmd_ready_w", cmd_ready, 1'b0);
      hs = wd_valid && axi.wready;
      if (hs) beat++;
      step();
      cyc++;
      if (hs) wd_valid = 1'b0;
    end
    wd_valid   = 1'b0;
    axi.wready = 1'b0;
    chk("w_beats", beat, exp_beats);
  endtask

  task automatic b_phase(input logic [1:0] bresp, input bit stall);
    bit done;
    int cyc;
    done = 1'b0;
    cyc  = 0;
    axi.wready = 1'b1;
    while (!done && cyc < Budget) begin
      axi.bvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.bresp  = bresp;
      #1;
      chk("bready", axi.bready, 1'b1);
      chk("wd_ready_b", wd_ready, 1'b0);
      chk("cmd_ready_b", cmd_ready, 1'b0);
      done = axi.bvalid;
      step();
      cyc++;
    end
    axi.bvalid = 1'b0;
    axi.wready = 1'b0;
    chk("b_done", done, 1'b1);
  endtask

  task automatic r_phase(input int len, input logic [7:0] resp4, input int last_at,
                         input bit stall);
    int beat;
    int cyc;
    bit hs;
    bit done;
    beat = 0;
    cyc  = 0;
    done = 1'b0;
    axi.rvalid = 1'b0;
    while (!done && cyc < Budget) begin
      if (!axi.rvalid) axi.rvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      axi.rdata = 32'hA500_0000 + 32'(beat);
      axi.rresp = (beat < 4) ? resp4[beat*2 +: 2] : AXI_RESP_OKAY;
      axi.rlast = (beat == last_at);
      rd_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("rd_valid", rd_valid, axi.rvalid);
      chk("rready", axi.rready, rd_ready);
      chk("rd_data", rd_data, 32'hA500_0000 + 32'(beat));
      chk("rd_last", rd_last, beat >= len);
      chk("cmd_ready_r", cmd_ready, 1'b0);
      hs = axi.rvalid && rd_ready;
      if (hs) begin
        if (beat == last_at) done = 1'b1;
        beat++;
      end
      step();
      cyc++;
      if (hs) axi.rvalid = 1'b0;
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    rd_ready   = 1'b0;
    chk("r_done", done, 1'b1);
    chk("r_beats", beat, last_at + 1);
  endtask

  task automatic rsp_phase(input logic wr, input logic [1:0] exp_resp, input bit stall);
    bit done;
    int cyc;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < Budget) begin
      rsp_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_write", rsp_write, wr);
      chk("rsp_resp", rsp_resp, exp_resp);
      chk("cmd_ready_rsp", cmd_ready, 1'b0);
      done = rsp_ready;
      step();
      cyc++;
    end
    rsp_ready = 1'b0;
    chk("rsp_done", done, 1'b1);
    chk("idle_cmd_ready", cmd_ready, 1'b1);
    chk("idle_rsp_valid", rsp_valid, 1'b0);
    chk("idle_valids", {axi.awvalid, axi.arvalid, axi.bready}, 3'b000);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; wd_strb = '0;
    rd_ready = 1'b0; rsp_ready = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bid = '0; axi.bresp = '0; axi.bvalid = 1'b0;
    axi.arready = 1'b0;
    axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0; axi.rvalid = 1'b0;

    // Reset state, with live inputs to show the pass-throughs are gated.
    repeat (2) @(posedge clk);
    #1;
    wd_valid = 1'b1; axi.wready = 1'b1; axi.rvalid = 1'b1; rd_ready = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_aw_ar", {axi.awvalid, axi.arvalid}, 2'b00);
    chk("rst_w", {axi.wvalid, wd_ready}, 2'b00);
    chk("rst_r", {rd_valid, axi.rready}, 2'b00);
    chk("rst_b_rsp", {axi.bready, rsp_valid, rsp_resp}, 4'b0000);
    wd_valid = 1'b0; axi.wready = 1'b0; axi.rvalid = 1'b0; rd_ready = 1'b0;
    nreset = 1'b1;
    step();

    // Single-beat write.
    send_cmd(1'b1, 16'h0010, 8'd0);
    addr_phase(1'b1, 16'h0010, 8'd0, 1'b0);
    wdata_phase(0, 32'hDEAD_BEEF, 1'b0, 256, 1);
    b_phase(AXI_RESP_OKAY, 1'b0);
    rsp_phase(1'b1, 2'b00, 1'b0);

    // 4-beat read from an unaligned address.
    send_cmd(1'b0, 16'h0103, 8'd3);
    addr_phase(1'b0, 16'h0100, 8'd3, 1'b0);
    r_phase(3, 8'h00, 3, 1'b0);
    rsp_phase(1'b0, 2'b00, 1'b0);

    // Error merge: OKAY, DECERR, SLVERR, OKAY -> first non-OKAY (DECERR).
    send_cmd(1'b0, 16'h0200, 8'd3);
    addr_phase(1'b0, 16'h0200, 8'd3, 1'b0);
    r_phase(3, 8'b00_10_11_00, 3, 1'b0);
    rsp_phase(1'b0, 2'b11, 1'b0);

    // Early rlast on the second beat of a 4-beat burst.
    send_cmd(1'b0, 16'h0300, 8'd3);
    addr_phase(1'b0, 16'h0300, 8'd3, 1'b0);
    r_phase(3, 8'h00, 1, 1'b0);
    rsp_phase(1'b0, 2'b10, 1'b0);

    // Missing rlast on the final beat; slave ends one beat late.
    send_cmd(1'b0, 16'h0408, 8'd1);
    addr_phase(1'b0, 16'h0408, 8'd1, 1'b0);
    r_phase(1, 8'h00, 2, 1'b0);
    rsp_phase(1'b0, 2'b10, 1'b0);

    // 256-beat write and read under random backpressure.
    send_cmd(1'b1, 16'h1004, 8'd255);
    addr_phase(1'b1, 16'h1004, 8'd255, 1'b1);
    wdata_phase(255, 32'h1000_0000, 1'b1, 256, 256);
    b_phase(AXI_RESP_EXOKAY, 1'b1);
    rsp_phase(1'b1, 2'b01, 1'b1);

    send_cmd(1'b0, 16'h2002, 8'd255);
    addr_phase(1'b0, 16'h2000, 8'd255, 1'b1);
    r_phase(255, 8'h00, 255, 1'b1);
    rsp_phase(1'b0, 2'b00, 1'b1);

    // Reset during beat 5 of an 8-beat write.
    send_cmd(1'b1, 16'h0500, 8'd7);
    addr_phase(1'b1, 16'h0500, 8'd7, 1'b0);
    wdata_phase(7, 32'h5000_0000, 1'b0, 4, 4);
    wd_valid = 1'b1; wd_data = 32'h5000_0004; axi.wready = 1'b1;
    #1;
    chk("mid_wvalid", axi.wvalid, 1'b1);
    chk("mid_wlast", axi.wlast, 1'b0);
    nreset = 1'b0;
    #1;
    chk("mrst_wvalid", {axi.wvalid, wd_ready}, 2'b00);
    chk("mrst_cmd_ready", cmd_ready, 1'b1);
    step();
    chk("mrst_valids", {axi.awvalid, axi.arvalid, axi.wvalid, axi.bready, rsp_valid}, 5'b0);
    chk("mrst_cmd_ready_next", cmd_ready, 1'b1);
    wd_valid = 1'b0; axi.wready = 1'b0;
    nreset = 1'b1;
    step();

    send_cmd(1'b0, 16'h0044, 8'd0);
    addr_phase(1'b0, 16'h0044, 8'd0, 1'b0);
    r_phase(0, 8'h00, 0, 1'b0);
    rsp_phase(1'b0, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sb_axi_burst_ctrl.md
Name: sb_axi_burst_ctrl

Overview:
- Single-outstanding AXI4 burst sequencer that drives a sim-side AXI master port from a simple command/data/response interface.
- Accepts one read or write command and issues AR or AW. Streams W beats from a data FIFO-style input and returns R beats to the requester. Collects B or R status and emits one response per command.
- Sits between a requester and the AXI master channel queues, and fully sequences AW/W/B/AR/R ordering.

Parameters:
- DATA_WIDTH, 32, AXI data width; power of two, at least 8.
- ADDR_WIDTH, 16, AXI address width.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.
- ID_WIDTH, 8, AXI ID width.
- AXI_ID, 0, constant ID driven on awid/arid.

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous active-low reset.
- cmd_valid/cmd_ready  in/out  1/1  command handshake.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_WIDTH  byte address of first beat.
- cmd_len  input  8  beats minus one (AXI len encoding).
- wd_valid/wd_ready  in/out  1/1  write-data handshake.
- wd_data, wd_strb  input  DATA_WIDTH, STRB_WIDTH  write beat payload.
- rd_valid/rd_ready  out/in  1/1  read-data handshake.
- rd_data, rd_last  output  DATA_WIDTH, 1  read beat and final-beat flag.
- rsp_valid/rsp_ready  out/in  1/1  completion handshake.
- rsp_write, rsp_resp  output  1, 2  command type, merged response.
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,valid}  output  per AXI4  write address.
- m_axi_awready  input  1.
- m_axi_w{data,strb,last,valid}  output  per AXI4  write data.
- m_axi_wready  input  1.
- m_axi_b{id,resp,valid}  input  per AXI4  write response.
- m_axi_bready  output  1.
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,valid}  output  per AXI4  read address.
- m_axi_arready  input  1.
- m_axi_r{id,data,resp,last,valid}  input  per AXI4  read data.
- m_axi_rready  output  1.

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (nreset).
- Reset: FSM in IDLE. All valid/ready outputs are 0, except cmd_ready=1. Beat counter, latched address/len and sticky resp are 0.
- Constant AXI fields:
  - size = log2(STRB_WIDTH), burst = INCR (2'b01), lock = 0, cache = 4'b0011, prot = 3'b000, id = AXI_ID.
  - addr is cmd_addr with its low log2(STRB_WIDTH) bits forced to 0.
  - 4 KB crossing is the requester's responsibility and is not checked.
- FSM states: IDLE, AW, W, B, AR, R, RSP.
- IDLE:
  - cmd_ready=1. On cmd_valid, latch addr/len/write.
  - Go to AW if write, else AR. Clear beat counter and sticky resp.
- AW / AR:
  - awvalid/arvalid held high from the first cycle in state until ready.
  - Payload is stable while valid. On handshake, go to W or R.
- W:
  - m_axi_wvalid = wd_valid and wd_ready = m_axi_wready, as a combinational pass-through with zero added latency.
  - wlast = (count == len). Count increments on each W handshake.
  - The beat with wlast goes to B.
- B:
  - bready=1. On bvalid, resp = bresp; go to RSP.
  - bid is ignored.
- R:
  - rd_valid = rvalid and rready = rd_ready, as a combinational pass-through; rd_data = rdata.
  - rd_last = (count == len).
  - On each handshake, sticky resp takes rresp if sticky is still OKAY (first non-OKAY wins).
  - rlast asserted with count != len, or count == len without rlast: force resp = SLVERR (2'b10).
  - Leave R only on the rlast handshake, then go to RSP.
- RSP:
  - rsp_valid=1 with rsp_write/rsp_resp. On rsp_ready, go to IDLE.
  - cmd_ready stays 0 until IDLE.
- Counter is 8 bits. len = 255 counts 0..255 without wrap.
- Back-to-back commands: minimum one idle cycle between an RSP handshake and the next cmd accept.
- nreset asserted mid-burst: immediate return to reset state. No cleanup of the AXI side; the bench resets both sides.
- Write beats are accepted only in state W. wd_ready=0 elsewhere.

Decomposition:
- Shared package sb_axi_pkg holds:
  - AXI_BURST_INCR, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR, AXI_CACHE_DEFAULT.
  - FSM state enum typedef.
  - Function axi_size_of(strb_width).
- No sub-module. The FSM plus counter is a single module.

Test Plan:
- Single-beat write: addr 0x0010, len 0, data 0xDEADBEEF, bresp OKAY → one AW (awlen 0, awsize 2), one W with wlast=1, rsp_write=1, rsp_resp=0.
- 4-beat read: addr 0x0103 (unaligned), len 3, rresp all OKAY → araddr 0x0100, 4 rd beats with rd_last only on the 4th, rsp_resp=0.
- Read error merge: 4 beats with rresp OKAY, DECERR, SLVERR, OKAY → rsp_resp=2'b11.
- Protocol error: rlast on beat 2 of len=3 → rsp_resp=2'b10, FSM returns to IDLE after RSP.
- Backpressure: random awready/wready/bvalid/rd_ready/rsp_ready stalls on 256-beat write and read → all beats delivered in order, valid never drops before ready, cmd_ready=0 until RSP completes.
- Reset mid-burst: nreset low during W beat 5 of 8 → next cycle all valids are 0 and cmd_ready=1; a new single-beat read completes normally.
